// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field widths, the flit packing helper and the
// injection scheduler state encoding.
package noc_pkg;

    localparam int WIDTH_packet = 28;
    localparam int WIDTH_addr   = 3;
    localparam int WIDTH_dest   = 3;
    localparam int WIDTH_flit   = WIDTH_packet + WIDTH_addr + WIDTH_dest;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } inj_state_t;

    // Router flit layout, MSB first: payload, source address, destination.
    function automatic logic [WIDTH_flit-1:0] pack_flit(
        input logic [WIDTH_packet-1:0] payload,
        input logic [WIDTH_addr-1:0]   addr,
        input logic [WIDTH_dest-1:0]   dest
    );
        return {payload, addr, dest};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request searching
// upward from ptr+1 (mod N); the pointer register lives in the caller.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic          found;
    logic [IW-1:0] idx;

    // NOTE: every signal driven here gets a default before any branch, otherwise
    // paths that skip an assignment would infer latches.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(ptr) + off) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/noc_injection_scheduler.sv
// Shares one NoC injection port among NUM_REQ sources: round-robin grant,
// one-entry output register, fixed injection budget ending in DONE.
module noc_injection_scheduler #(
    parameter  int NUM_REQ      = 4,
    parameter  int WIDTH_packet = noc_pkg::WIDTH_packet,
    parameter  int WIDTH_addr   = noc_pkg::WIDTH_addr,
    parameter  int WIDTH_dest   = noc_pkg::WIDTH_dest,
    parameter  int NUM_PACKETS  = 20,
    localparam int WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W        = $clog2(NUM_PACKETS + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*WIDTH_packet-1:0] req_data,
    input  logic [NUM_REQ*WIDTH_dest-1:0]   req_dest,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_packet,
    output logic [CNT_W-1:0]                sent_count,
    output logic [IDX_W-1:0]                last_grant,
    output logic                            done
);
    import noc_pkg::*;

    inj_state_t              state, state_next;
    logic                    load;
    logic                    budget_left;
    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        grant_idx;
    logic [WIDTH_packet-1:0] sel_data;
    logic [WIDTH_dest-1:0]   sel_dest;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (last_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign budget_left = (sent_count < CNT_W'(NUM_PACKETS));

    // rst_n gates load so req_ready stays low while reset is held.
    assign load = rst_n && enable && (state != DONE) && budget_left && (|req_valid)
                  && ((state == IDLE) || ((state == HOLD) && out_ready));

    always_comb begin
        sel_data = '0;
        sel_dest = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*WIDTH_packet +: WIDTH_packet];
                sel_dest = req_dest[i*WIDTH_dest +: WIDTH_dest];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (load) state_next = HOLD;
            HOLD: begin
                if (load)
                    state_next = HOLD;
                else if (out_ready)
                    state_next = (sent_count == CNT_W'(NUM_PACKETS)) ? DONE : IDLE;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = load ? grant : '0;
        out_valid = (state == HOLD);
        done      = (state == DONE);
    end

    // The held packet is discarded on reset so a stale flit never reaches the router.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_packet <= '0;
            sent_count <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (load) begin
            out_packet <= {sel_data, WIDTH_addr'(grant_idx), sel_dest};
            sent_count <= sent_count + CNT_W'(1);
            last_grant <= grant_idx;
        end
    end

endmodule

// File: tb/tb_noc_injection_scheduler.sv
// Scoreboard bench for noc_injection_scheduler: a transaction-level model
// predicts grants and packets; a separate monitor checks every held packet.
module tb_noc_injection_scheduler;
    import noc_pkg::*;

    localparam int NR = 4;
    localparam int NP = 20;
    localparam int WP = noc_pkg::WIDTH_packet;
    localparam int WA = noc_pkg::WIDTH_addr;
    localparam int WD = noc_pkg::WIDTH_dest;
    localparam int W  = WP + WA + WD;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*WP-1:0]  req_data = '0;
    logic [NR*WD-1:0]  req_dest = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      out_packet;
    logic [4:0]        sent_count;
    logic [1:0]        last_grant;
    logic              done;

    noc_injection_scheduler #(
        .NUM_REQ     (NR),
        .WIDTH_packet(WP),
        .WIDTH_addr  (WA),
        .WIDTH_dest  (WD),
        .NUM_PACKETS (NP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_dest   (req_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet),
        .sent_count (sent_count),
        .last_grant (last_grant),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction-level view of the scheduler.
    bit           m_hold;
    int           m_cnt;
    int           m_ptr;
    bit           m_done;
    logic [W-1:0] exp_q[$];
    bit           mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_hold = 1'b0;
        m_cnt  = 0;
        m_ptr  = NR - 1;
        m_done = 1'b0;
        exp_q.delete();
    endtask

    task automatic gen(output logic [NR*WP-1:0] d, output logic [NR*WD-1:0] ds);
        for (int i = 0; i < NR; i++) begin
            d[i*WP +: WP]  = WP'($urandom);
            ds[i*WD +: WD] = WD'($urandom);
        end
    endtask

    // One clock cycle: drive at negedge, compare registered state and the
    // combinational grant, then advance the model across the coming posedge.
    task automatic step(input logic [NR-1:0] v, input bit ordy, input bit en,
                        input logic [NR*WP-1:0] d, input logic [NR*WD-1:0] ds);
        logic [NR-1:0] exp_ready;
        int            w;
        bit            ld;
        @(negedge clk);
        req_valid = v;
        out_ready = ordy;
        enable    = en;
        req_data  = d;
        req_dest  = ds;
        #1;
        check("out_valid",  64'(out_valid),  64'(m_hold));
        check("sent_count", 64'(sent_count), 64'(m_cnt));
        check("last_grant", 64'(last_grant), 64'(m_ptr));
        check("done",       64'(done),       64'(m_done));
        ld = en && !m_done && (m_cnt < NP) && (v != '0) && (!m_hold || ordy);
        exp_ready = '0;
        w = -1;
        if (ld) begin
            w = pick(v, m_ptr);
            exp_ready[w] = 1'b1;
            exp_q.push_back(pack_flit(d[w*WP +: WP], WA'(w), ds[w*WD +: WD]));
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (ld) begin
            m_hold = 1'b1;
            m_cnt++;
            m_ptr = w;
        end else if (m_hold && ordy) begin
            m_hold = 1'b0;
            if (m_cnt == NP) m_done = 1'b1;
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        enable    = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_req_ready",  64'(req_ready),  64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    // Monitor: whenever a packet is presented it must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_spurious", 64'(out_valid), 64'(0));
                end else begin
                    check("out_packet", 64'(out_packet), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [NR*WP-1:0] d;
        logic [NR*WD-1:0] ds;
        logic [W-1:0]     flit_abc;
        model_reset();
        do_reset();

        // Single requester 0, fixed payload and destination.
        d = '0;
        d[WP-1:0] = 28'h0000ABC;
        ds = '0;
        ds[WD-1:0] = 3'b001;
        flit_abc = {28'h0000ABC, 3'b000, 3'b001};
        step(4'b0001, 1'b1, 1'b1, d, ds);
        step(4'b0000, 1'b1, 1'b1, d, ds);
        check("single_packet", 64'(out_packet), 64'(flit_abc));
        step(4'b0000, 1'b1, 1'b1, d, ds);

        // All requesters valid, dests 1..4: rotating grants, one per cycle.
        ds = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 8; i++) begin
            gen(d, ds);
            ds = {3'd4, 3'd3, 3'd2, 3'd1};
            step(4'hF, 1'b1, 1'b1, d, ds);
        end

        // Router stalls for five cycles, then drain and reload together.
        for (int i = 0; i < 5; i++) begin
            gen(d, ds);
            step(4'hF, 1'b0, 1'b1, d, ds);
        end
        gen(d, ds);
        step(4'hF, 1'b1, 1'b1, d, ds);

        // Enable drops while a packet is held; rotation resumes afterwards.
        gen(d, ds);
        step(4'hF, 1'b0, 1'b0, d, ds);
        step(4'hF, 1'b1, 1'b0, d, ds);
        step(4'hF, 1'b1, 1'b0, d, ds);
        step(4'hF, 1'b1, 1'b1, d, ds);

        // Run out the budget and keep requesting past DONE.
        for (int i = 0; i < 20; i++) begin
            gen(d, ds);
            step(4'hF, 1'b1, 1'b1, d, ds);
        end
        check("budget_count", 64'(sent_count), 64'(NP));
        check("budget_done",  64'(done),       64'(1));

        // Asynchronous reset while a packet is held.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            gen(d, ds);
            step(4'hF, 1'b1, 1'b1, d, ds);
        end
        step(4'hF, 1'b0, 1'b1, d, ds);
        mon_en = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_out_valid",  64'(out_valid),  64'(0));
        check("async_out_packet", 64'(out_packet), 64'(0));
        check("async_sent_count", 64'(sent_count), 64'(0));
        check("async_last_grant", 64'(last_grant), 64'(NR - 1));
        check("async_done",       64'(done),       64'(0));
        check("async_req_ready",  64'(req_ready),  64'(0));
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        gen(d, ds);
        step(4'hF, 1'b1, 1'b1, d, ds);

        // Randomized traffic over several budgets.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 70; i++) begin
                gen(d, ds);
                step(NR'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0), d, ds);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
